// File: rtl/wb_port_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter: packet layout,
// arbiter FSM encoding and default sizing.
package wb_port_arbiter_pkg;

   localparam int PKT_W         = 12;
   localparam int ENTRY_W       = 11;
   localparam int REG_WRITE_BIT = 11;
   localparam int DATA_MSB      = 10;
   localparam int DATA_LSB      = 3;
   localparam int RD_MSB        = 2;
   localparam int RD_LSB        = 0;

   localparam int DEFAULT_DEPTH        = 2;
   localparam int DEFAULT_STARVE_LIMIT = 4;

   typedef enum logic [1:0] {
      ST_NORMAL = 2'd0,
      ST_ARM    = 2'd1,
      ST_FORCE  = 2'd2
   } arb_state_e;

endpackage

// File: rtl/wb_port_arbiter_fifo.sv
// wb_req_fifo: small circular FIFO holding multi-cycle writeback requests
// as {data, rd}; pointers wrap modulo DEPTH.
module wb_req_fifo
   import wb_port_arbiter_pkg::*;
#(
   parameter int DEPTH = DEFAULT_DEPTH,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               push,
   input  logic [ENTRY_W-1:0] push_entry,
   input  logic               pop,
   output logic [ENTRY_W-1:0] head,
   output logic [CNT_W-1:0]   count
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [ENTRY_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   always_comb begin
      wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      count_d  = count_q;
      if (push && !pop)
         count_d = count_q + CNT_W'(1);
      else if (pop && !push)
         count_d = count_q - CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      if (push)
         mem_q[wr_ptr_q] <= push_entry;
   end

   assign head  = mem_q[rd_ptr_q];
   assign count = count_q;

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single register-file write port between the pipeline
// writeback and a FIFO of multi-cycle results, with starvation forcing.
module wb_port_arbiter
   import wb_port_arbiter_pkg::*;
#(
   parameter int DEPTH        = DEFAULT_DEPTH,
   parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [PKT_W-1:0] pl_wb,
   input  logic             mc_valid,
   input  logic [7:0]       mc_data,
   input  logic [2:0]       mc_rd,
   output logic             mc_ready,
   output logic             stall,
   output logic             rf_we,
   output logic [2:0]       rf_waddr,
   output logic [7:0]       rf_wdata,
   output logic [1:0]       fifo_count,
   output logic             drop_err
);

   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int STV_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

   arb_state_e         state_q, state_d;
   logic [STV_W-1:0]   starve_q, starve_d;
   logic               stall_q, stall_d;
   logic               rf_we_q, rf_we_d;
   logic [2:0]         rf_waddr_q, rf_waddr_d;
   logic [7:0]         rf_wdata_q, rf_wdata_d;
   logic               drop_err_q, drop_err_d;

   logic               pl_req;
   logic               grant_pl, grant_fifo;
   logic               fifo_push, fifo_empty;
   logic [ENTRY_W-1:0] fifo_head;
   logic [CNT_W-1:0]   fifo_cnt;

   assign pl_req     = pl_wb[REG_WRITE_BIT];
   assign fifo_empty = (fifo_cnt == '0);
   assign mc_ready   = (fifo_cnt < CNT_W'(DEPTH));
   assign fifo_push  = mc_valid && mc_ready;

   wb_req_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .push       (fifo_push),
      .push_entry ({mc_data, mc_rd}),
      .pop        (grant_fifo),
      .head       (fifo_head),
      .count      (fifo_cnt)
   );

   always_comb begin
      state_d    = state_q;
      drop_err_d = drop_err_q;
      grant_pl   = 1'b0;
      grant_fifo = 1'b0;
      case (state_q)
         ST_FORCE: begin
            // The FIFO owns the port this cycle; a pipeline write is lost.
            grant_fifo = !fifo_empty;
            if (pl_req)
               drop_err_d = 1'b1;
            state_d = ST_NORMAL;
         end
         ST_ARM: begin
            grant_pl   = pl_req;
            grant_fifo = !pl_req && !fifo_empty;
            state_d    = ST_FORCE;
         end
         default: begin
            grant_pl   = pl_req;
            grant_fifo = !pl_req && !fifo_empty;
         end
      endcase

      starve_d = starve_q;
      if (state_q == ST_FORCE || fifo_empty || grant_fifo)
         starve_d = '0;
      else if (starve_q < STV_W'(STARVE_LIMIT))
         starve_d = starve_q + STV_W'(1);

      if (state_q == ST_NORMAL && starve_d >= STV_W'(STARVE_LIMIT))
         state_d = ST_ARM;

      stall_d    = (state_d == ST_ARM);
      rf_we_d    = grant_pl || grant_fifo;
      rf_waddr_d = rf_waddr_q;
      rf_wdata_d = rf_wdata_q;
      if (grant_pl) begin
         rf_waddr_d = pl_wb[RD_MSB:RD_LSB];
         rf_wdata_d = pl_wb[DATA_MSB:DATA_LSB];
      end else if (grant_fifo) begin
         rf_waddr_d = fifo_head[RD_MSB:RD_LSB];
         rf_wdata_d = fifo_head[DATA_MSB:DATA_LSB];
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= ST_NORMAL;
         starve_q   <= '0;
         stall_q    <= 1'b0;
         rf_we_q    <= 1'b0;
         rf_waddr_q <= '0;
         rf_wdata_q <= '0;
         drop_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         starve_q   <= starve_d;
         stall_q    <= stall_d;
         rf_we_q    <= rf_we_d;
         rf_waddr_q <= rf_waddr_d;
         rf_wdata_q <= rf_wdata_d;
         drop_err_q <= drop_err_d;
      end
   end

   assign stall      = stall_q;
   assign rf_we      = rf_we_q;
   assign rf_waddr   = rf_waddr_q;
   assign rf_wdata   = rf_wdata_q;
   assign drop_err   = drop_err_q;
   assign fifo_count = 2'(fifo_cnt);

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed and randomized bench for wb_port_arbiter against a queue-based
// model of the arbitration rules.
module tb_wb_port_arbiter;

   localparam int DEPTH = 2;
   localparam int LIMIT = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [11:0] pl_wb = '0;
   logic        mc_valid = 1'b0;
   logic [7:0]  mc_data = '0;
   logic [2:0]  mc_rd = '0;
   logic        mc_ready, stall, rf_we, drop_err;
   logic [2:0]  rf_waddr;
   logic [7:0]  rf_wdata;
   logic [1:0]  fifo_count;

   always #5 clk = ~clk;

   wb_port_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
      .clk        (clk),
      .reset      (reset),
      .pl_wb      (pl_wb),
      .mc_valid   (mc_valid),
      .mc_data    (mc_data),
      .mc_rd      (mc_rd),
      .mc_ready   (mc_ready),
      .stall      (stall),
      .rf_we      (rf_we),
      .rf_waddr   (rf_waddr),
      .rf_wdata   (rf_wdata),
      .fifo_count (fifo_count),
      .drop_err   (drop_err)
   );

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   bit checking = 0;

   // Model state: pending multi-cycle requests in arrival order, cycles the
   // oldest one has waited, and whether we are in the warning / forced cycle.
   logic [10:0] q[$];
   int          starve;
   bit          m_warn, m_forced, m_drop, m_we, m_zero;
   logic [2:0]  m_waddr;
   logic [7:0]  m_wdata;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp)
      else begin
         fails++;
         $error("FAIL %s (cycle %0d): observed %0h expected %0h", tag, cyc, got, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      starve   = 0;
      m_warn   = 0;
      m_forced = 0;
      m_drop   = 0;
      m_we     = 0;
      m_zero   = 1;
      m_waddr  = '0;
      m_wdata  = '0;
   endtask

   task automatic check_outputs();
      chk("mc_ready",   32'(mc_ready),   32'(q.size() < DEPTH));
      chk("fifo_count", 32'(fifo_count), 32'(q.size()));
      chk("stall",      32'(stall),      32'(m_warn));
      chk("rf_we",      32'(rf_we),      32'(m_we));
      chk("drop_err",   32'(drop_err),   32'(m_drop));
      if (m_we || m_zero) begin
         chk("rf_waddr", 32'(rf_waddr), 32'(m_waddr));
         chk("rf_wdata", 32'(rf_wdata), 32'(m_wdata));
      end
   endtask

   task automatic model_step(input logic [11:0] pl, input logic mv, input logic [7:0] md,
                             input logic [2:0] mr, output bit xfer);
      bit          pl_req;
      bit          g_pl;
      bit          g_f;
      bit          next_warn;
      logic [10:0] head;
      pl_req = pl[11];
      g_pl   = 0;
      g_f    = 0;
      xfer   = mv && (q.size() < DEPTH);
      if (m_forced) begin
         g_f = (q.size() > 0);
         if (pl_req) m_drop = 1;
      end else if (pl_req) begin
         g_pl = 1;
      end else begin
         g_f = (q.size() > 0);
      end
      if (m_forced || q.size() == 0 || g_f) starve = 0;
      else if (starve < LIMIT) starve++;
      next_warn = !m_warn && !m_forced && (starve >= LIMIT);
      m_forced  = m_warn;
      m_warn    = next_warn;
      m_we      = g_pl || g_f;
      if (g_pl) begin
         m_waddr = pl[2:0];
         m_wdata = pl[10:3];
         m_zero  = 0;
      end else if (g_f) begin
         head    = q.pop_front();
         m_waddr = head[2:0];
         m_wdata = head[10:3];
         m_zero  = 0;
      end
      if (xfer) q.push_back({md, mr});
   endtask

   task automatic cycle(input logic rst_n, input logic [11:0] pl, input logic mv,
                        input logic [7:0] md, input logic [2:0] mr, output bit xfer);
      @(negedge clk);
      cyc++;
      reset    = rst_n;
      pl_wb    = pl;
      mc_valid = mv;
      mc_data  = md;
      mc_rd    = mr;
      #1;
      if (checking) check_outputs();
      xfer = 0;
      if (!rst_n) model_reset();
      else model_step(pl, mv, md, mr, xfer);
   endtask

   initial begin
      bit          x;
      bit          pend;
      logic [7:0]  pd;
      logic [2:0]  pr;
      logic [11:0] rpl;

      model_reset();
      repeat (2) cycle(1'b0, 12'h000, 1'b0, 8'h00, 3'd0, x);
      checking = 1;

      // Idle after reset.
      repeat (10) cycle(1'b1, 12'h000, 1'b0, 8'h00, 3'd0, x);

      // Single pipeline write.
      cycle(1'b1, {1'b1, 8'hA5, 3'd3}, 1'b0, 8'h00, 3'd0, x);
      cycle(1'b1, 12'h000, 1'b0, 8'h00, 3'd0, x);
      chk("pl_write_we",   32'(rf_we),    32'd1);
      chk("pl_write_addr", 32'(rf_waddr), 32'd3);
      chk("pl_write_data", 32'(rf_wdata), 32'hA5);

      // Multi-cycle only.
      cycle(1'b1, 12'h000, 1'b1, 8'h3C, 3'd5, x);
      cycle(1'b1, 12'h000, 1'b0, 8'h00, 3'd0, x);
      cycle(1'b1, 12'h000, 1'b0, 8'h00, 3'd0, x);
      chk("mc_write_data",  32'(rf_wdata),   32'h3C);
      chk("mc_write_addr",  32'(rf_waddr),   32'd5);
      chk("mc_fifo_empty",  32'(fifo_count), 32'd0);

      // Fill the FIFO while the pipeline is busy; third request must wait.
      cycle(1'b1, {1'b1, 8'h01, 3'd2}, 1'b1, 8'h51, 3'd6, x);
      cycle(1'b1, {1'b1, 8'h02, 3'd2}, 1'b1, 8'h52, 3'd7, x);
      cycle(1'b1, {1'b1, 8'h03, 3'd2}, 1'b1, 8'h53, 3'd4, x);
      chk("full_count", 32'(fifo_count), 32'd2);
      chk("full_ready", 32'(mc_ready),   32'd0);
      pend = 1;
      for (int i = 0; i < 10 && pend; i++) begin
         cycle(1'b1, 12'h000, 1'b1, 8'h53, 3'd4, x);
         if (x) pend = 0;
      end
      chk("held_req_accepted", 32'(pend), 32'd0);
      repeat (6) cycle(1'b1, 12'h000, 1'b0, 8'h00, 3'd0, x);

      // Starvation: pipeline writes every cycle.
      cycle(1'b1, {1'b1, 8'h70, 3'd0}, 1'b1, 8'h11, 3'd1, x);
      for (int k = 1; k <= 7; k++) begin
         cycle(1'b1, {1'b1, 8'(8'h70 + k), 3'(k)}, 1'b0, 8'h00, 3'd0, x);
         if (k == 5) chk("starve_stall", 32'(stall), 32'd1);
         if (k == 7) begin
            chk("forced_addr", 32'(rf_waddr), 32'd1);
            chk("forced_data", 32'(rf_wdata), 32'h11);
            chk("drop_set",    32'(drop_err), 32'd1);
         end
      end
      repeat (4) cycle(1'b1, 12'h000, 1'b0, 8'h00, 3'd0, x);
      chk("drop_sticky", 32'(drop_err), 32'd1);

      // Reset while the FIFO holds entries.
      cycle(1'b1, {1'b1, 8'h21, 3'd2}, 1'b1, 8'h61, 3'd3, x);
      cycle(1'b1, {1'b1, 8'h22, 3'd2}, 1'b1, 8'h62, 3'd4, x);
      cycle(1'b0, {1'b1, 8'h23, 3'd2}, 1'b0, 8'h00, 3'd0, x);
      cycle(1'b1, 12'h000, 1'b0, 8'h00, 3'd0, x);
      chk("rst_count", 32'(fifo_count), 32'd0);
      chk("rst_we",    32'(rf_we),      32'd0);
      chk("rst_drop",  32'(drop_err),   32'd0);
      repeat (3) cycle(1'b1, 12'h000, 1'b0, 8'h00, 3'd0, x);

      // Randomized traffic with valid held until accepted.
      pend = 0;
      pd   = '0;
      pr   = '0;
      for (int n = 0; n < 800; n++) begin
         if (!pend && ($urandom_range(0, 2) != 0)) begin
            pend = 1;
            pd   = 8'($urandom);
            pr   = 3'($urandom);
         end
         rpl = 12'($urandom);
         rpl[11] = ($urandom_range(0, 9) < 7);
         if ($urandom_range(0, 199) == 0) begin
            cycle(1'b0, rpl, pend, pd, pr, x);
            pend = 0;
         end else begin
            cycle(1'b1, rpl, pend, pd, pr, x);
            if (x) pend = 0;
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
